// File: rtl/int_issue_select_if.sv
// rtl/int_issue_select_if.sv - payload types and integer issue queue snapshot interface
package int_issue_pkg;
  localparam int PREG_W      = 6;
  localparam int IMM_W       = 16;
  localparam int ALU_CTL_W   = 4;
  localparam int AL_ID_W     = 5;
  localparam int ISSUE_IDX_W = 6;

  typedef struct packed {
    logic [ISSUE_IDX_W-1:0] issue_index;
    logic [PREG_W-1:0]      src1;
    logic [PREG_W-1:0]      src2;
    logic [PREG_W-1:0]      dest;
    logic [IMM_W-1:0]       immediate;
    logic [ALU_CTL_W-1:0]   alu_ctl;
    logic                   is_branch;
    logic                   branch_pred_taken;
    logic                   uses_src1;
    logic                   uses_src2;
    logic                   uses_imm;
    logic                   uses_dest;
    logic [AL_ID_W-1:0]     active_list_id;
  } int_issue_payload_t;
endpackage

interface integer_issue_queue_ifc #(
  parameter int INT_QUEUE_SIZE = 8
);
  import int_issue_pkg::*;

  logic [INT_QUEUE_SIZE-1:0]                entry_available_bit;
  logic [INT_QUEUE_SIZE-1:0]                ready_bit_src1;
  logic [INT_QUEUE_SIZE-1:0]                ready_bit_src2;
  logic [INT_QUEUE_SIZE-1:0][PREG_W-1:0]    src1;
  logic [INT_QUEUE_SIZE-1:0][PREG_W-1:0]    src2;
  logic [INT_QUEUE_SIZE-1:0][PREG_W-1:0]    dest;
  logic [INT_QUEUE_SIZE-1:0][IMM_W-1:0]     immediate;
  logic [INT_QUEUE_SIZE-1:0][ALU_CTL_W-1:0] alu_ctl;
  logic [INT_QUEUE_SIZE-1:0]                is_branch;
  logic [INT_QUEUE_SIZE-1:0]                branch_pred_taken;
  logic [INT_QUEUE_SIZE-1:0]                uses_src1;
  logic [INT_QUEUE_SIZE-1:0]                uses_src2;
  logic [INT_QUEUE_SIZE-1:0]                uses_imm;
  logic [INT_QUEUE_SIZE-1:0]                uses_dest;
  logic [INT_QUEUE_SIZE-1:0][AL_ID_W-1:0]   active_list_id;

  modport in (
    input entry_available_bit, ready_bit_src1, ready_bit_src2,
    input src1, src2, dest, immediate, alu_ctl,
    input is_branch, branch_pred_taken,
    input uses_src1, uses_src2, uses_imm, uses_dest, active_list_id
  );
endinterface

// File: rtl/int_issue_select.sv
// rtl/int_issue_select.sv - age-matrix oldest-ready select with a one-entry issue register
module int_issue_select
  import int_issue_pkg::*;
#(
  parameter int INT_QUEUE_SIZE       = 8,
  parameter int INT_QUEUE_SIZE_INDEX = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  integer_issue_queue_ifc.in                   curr_int_queue,
  input  logic [1:0]                           alloc_valid,
  input  logic [1:0][INT_QUEUE_SIZE_INDEX-1:0] alloc_index,
  input  logic                                 flush,
  output logic                                 issue_valid,
  input  logic                                 issue_ready,
  output int_issue_payload_t                   issue_payload,
  output logic [INT_QUEUE_SIZE-1:0]            clear_mask,
  output logic [15:0]                          stall_cycles
);
  localparam int N = INT_QUEUE_SIZE;

  logic [N-1:0][N-1:0]             older_q, older_d;
  logic                            issue_valid_q, issue_valid_d;
  int_issue_payload_t              payload_q, payload_d;
  logic [N-1:0]                    clear_mask_q, clear_mask_d;
  logic [15:0]                     stall_q, stall_d;

  logic [N-1:0]                    occupied, occ_ext, cand, oldest, grant_oh;
  logic [INT_QUEUE_SIZE_INDEX-1:0] grant_idx, a;
  logic                            found, grant_en;
  int_issue_payload_t              sel;

  always_comb begin
    occupied = ~curr_int_queue.entry_available_bit;
    // The entry granted last cycle is still occupied in the snapshot until the queue sees clear_mask.
    cand = occupied & curr_int_queue.ready_bit_src1 & curr_int_queue.ready_bit_src2 & ~clear_mask_q;

    for (int i = 0; i < N; i++) begin
      oldest[i] = cand[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && cand[j] && older_q[j][i]) oldest[i] = 1'b0;
      end
    end

    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (oldest[i] && !found) begin
        grant_oh[i] = 1'b1;
        grant_idx   = INT_QUEUE_SIZE_INDEX'(i);
        found       = 1'b1;
      end
    end

    grant_en = found && (!issue_valid_q || issue_ready) && !flush;

    sel                   = '0;
    sel.issue_index       = ISSUE_IDX_W'(grant_idx);
    sel.src1              = curr_int_queue.src1[grant_idx];
    sel.src2              = curr_int_queue.src2[grant_idx];
    sel.dest              = curr_int_queue.dest[grant_idx];
    sel.immediate         = curr_int_queue.immediate[grant_idx];
    sel.alu_ctl           = curr_int_queue.alu_ctl[grant_idx];
    sel.is_branch         = curr_int_queue.is_branch[grant_idx];
    sel.branch_pred_taken = curr_int_queue.branch_pred_taken[grant_idx];
    sel.uses_src1         = curr_int_queue.uses_src1[grant_idx];
    sel.uses_src2         = curr_int_queue.uses_src2[grant_idx];
    sel.uses_imm          = curr_int_queue.uses_imm[grant_idx];
    sel.uses_dest         = curr_int_queue.uses_dest[grant_idx];
    sel.active_list_id    = curr_int_queue.active_list_id[grant_idx];

    // Slot 0 is folded into occ_ext before slot 1 so the slot 0 entry counts as older.
    older_d = older_q;
    occ_ext = occupied;
    a       = '0;
    if (flush) begin
      older_d = '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (alloc_valid[k]) begin
          a          = alloc_index[k];
          older_d[a] = '0;
          for (int j = 0; j < N; j++) begin
            older_d[j][a] = occ_ext[j] && (j != int'(a));
          end
          occ_ext[a] = 1'b1;
        end
      end
    end

    issue_valid_d = issue_valid_q;
    payload_d     = payload_q;
    clear_mask_d  = '0;
    if (flush) begin
      issue_valid_d = 1'b0;
    end else if (grant_en) begin
      issue_valid_d = 1'b1;
      payload_d     = sel;
      clear_mask_d  = grant_oh;
    end else if (issue_ready) begin
      issue_valid_d = 1'b0;
    end

    stall_d = stall_q;
    if (issue_valid_q && !issue_ready && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      older_q       <= '0;
      issue_valid_q <= 1'b0;
      payload_q     <= '0;
      clear_mask_q  <= '0;
      stall_q       <= '0;
    end else begin
      older_q       <= older_d;
      issue_valid_q <= issue_valid_d;
      payload_q     <= payload_d;
      clear_mask_q  <= clear_mask_d;
      stall_q       <= stall_d;
    end
  end

  assign issue_valid   = issue_valid_q;
  assign issue_payload = payload_q;
  assign clear_mask    = clear_mask_q;
  assign stall_cycles  = stall_q;
endmodule
